// File: rtl/uart_rx_oversampled_if.sv
// rtl/uart_rx_oversampled_if.sv - line input and received-frame outputs of the oversampled UART receiver
interface uart_rx_oversampled_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        input  rx,
        output data,
        output valid,
        output frame_err,
        output parity_err,
        output busy
    );

    modport slave (
        output rx,
        input  data,
        input  valid,
        input  frame_err,
        input  parity_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampled UART receiver, mid-bit sampling aligned to the start edge
module uart_rx_oversampled #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_rx_oversampled_if.master bus
);
    localparam longint TICK_RATE = longint'(BAUD) * longint'(OVERSAMPLE);
    localparam longint DIV_L     = (longint'(CLK_FREQ) + TICK_RATE / 2) / TICK_RATE;
    localparam int     DIV       = int'(DIV_L);
    localparam int     DW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int     SW        = $clog2(OVERSAMPLE);
    localparam int     BW        = $clog2(DATA_BITS);

    localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
    localparam logic [SW-1:0] SAMP_MID   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
    localparam logic          PAR_EXPECT = (PARITY == 1) ? 1'b1 : 1'b0;

    generate
        if (DIV_L < 1) begin : g_div_err
            $error("uart_rx_oversampled: CLK_FREQ too low for BAUD*OVERSAMPLE (divider < 1)");
        end
        if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8 || OVERSAMPLE > 16) begin : g_os_err
            $error("uart_rx_oversampled: OVERSAMPLE must be even and within 8..16");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_err
            $error("uart_rx_oversampled: DATA_BITS must be within 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_par_err
            $error("uart_rx_oversampled: PARITY must be 0, 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rxs;
    logic [DW-1:0]        div_cnt;
    logic [SW-1:0]        samp_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_flag;
    logic                 tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rxs     <= rx_meta;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    // samp_cnt counts ticks within the current bit; the action happens on the tick that completes the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            div_cnt        <= '0;
            samp_cnt       <= '0;
            bit_cnt        <= '0;
            shift          <= '0;
            par_flag       <= 1'b0;
            bus.data       <= '0;
            bus.valid      <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.valid      <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.parity_err <= 1'b0;
            div_cnt        <= tick ? '0 : div_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        state    <= ST_START;
                        bus.busy <= 1'b1;
                        div_cnt  <= '0;
                        samp_cnt <= '0;
                        par_flag <= 1'b0;
                    end
                end

                ST_START: begin
                    if (tick) begin
                        if (samp_cnt == SAMP_MID) begin
                            samp_cnt <= '0;
                            bit_cnt  <= '0;
                            if (!rxs) begin
                                state <= ST_DATA;
                            end else begin
                                state    <= ST_IDLE;
                                bus.busy <= 1'b0;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        if (samp_cnt == SAMP_LAST) begin
                            samp_cnt <= '0;
                            shift    <= {rxs, shift[DATA_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) begin
                                state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (tick) begin
                        if (samp_cnt == SAMP_LAST) begin
                            samp_cnt <= '0;
                            par_flag <= ((^shift) ^ rxs) != PAR_EXPECT;
                            state    <= ST_STOP;
                        end else begin
                            samp_cnt <= samp_cnt + 1'b1;
                        end
                    end
                end

                // Leaving at stop mid-bit lets the next start edge arrive with no idle gap
                ST_STOP: begin
                    if (tick) begin
                        if (samp_cnt == SAMP_LAST) begin
                            samp_cnt <= '0;
                            if (rxs) begin
                                bus.data       <= shift;
                                bus.valid      <= 1'b1;
                                bus.parity_err <= par_flag;
                                state          <= ST_IDLE;
                                bus.busy       <= 1'b0;
                            end else begin
                                bus.frame_err <= 1'b1;
                                state         <= ST_WAIT_IDLE;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + 1'b1;
                        end
                    end
                end

                ST_WAIT_IDLE: begin
                    if (rxs) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - scoreboard bench for uart_rx_oversampled (no-parity and even-parity instances)
module tb_uart_rx_oversampled;
    localparam int BIT_CLK = 160;

    typedef struct {
        bit         is_valid;
        logic [7:0] data;
        bit         perr;
        int         start_cyc;
        int         par;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;
    exp_t sb0[$];
    exp_t sb1[$];
    logic [7:0] last_data[2];

    uart_rx_oversampled_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_oversampled_if #(.DATA_BITS(8)) bus1 ();

    uart_rx_oversampled #(
        .CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.master)
    );

    uart_rx_oversampled #(
        .CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic handle(input int idx, input logic [2:0] flags, input logic [7:0] d);
        exp_t e;
        int   lat, lo, hi;
        bit   empty;
        empty = (idx == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
        if (empty) begin
            chk($sformatf("unexpected_event_dut%0d", idx), 32'(flags), 32'h0);
        end else begin
            if (idx == 0) e = sb0.pop_front();
            else e = sb1.pop_front();
            chk($sformatf("flags_dut%0d", idx), 32'(flags), 32'({e.is_valid, !e.is_valid, e.perr}));
            chk($sformatf("data_dut%0d", idx), 32'(d), 32'(e.data));
            lat = cyc - e.start_cyc;
            lo  = (9 + e.par) * BIT_CLK + BIT_CLK / 2 - 20;
            hi  = (9 + e.par) * BIT_CLK + BIT_CLK / 2 + 2 + 10;
            n_checks++;
            if (lat >= lo && lat <= hi) n_pass++;
            else $display("FAIL latency_dut%0d: got %0d clk, required %0d..%0d", idx, lat, lo, hi);
        end
    endtask

    always @(negedge clk) begin
        if (bus0.valid || bus0.frame_err || bus0.parity_err)
            handle(0, {bus0.valid, bus0.frame_err, bus0.parity_err}, bus0.data);
        if (bus1.valid || bus1.frame_err || bus1.parity_err)
            handle(1, {bus1.valid, bus1.frame_err, bus1.parity_err}, bus1.data);
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int idx, input logic b);
        if (idx == 0) bus0.rx = b;
        else bus1.rx = b;
    endtask

    // Dut 1 carries an even-parity bit; a low stop bit leaves the line low on return
    task automatic send_frame(input int idx, input logic [7:0] pl, input logic pbit, input logic stop);
        exp_t e;
        e.start_cyc = cyc;
        e.par       = idx;
        if (stop) begin
            e.is_valid = 1'b1;
            e.data     = pl;
            e.perr     = (idx == 1) ? ((($countones(pl) + int'(pbit)) % 2) != 0) : 1'b0;
            last_data[idx] = pl;
        end else begin
            e.is_valid = 1'b0;
            e.data     = last_data[idx];
            e.perr     = 1'b0;
        end
        if (idx == 0) sb0.push_back(e);
        else sb1.push_back(e);
        set_rx(idx, 1'b0);
        clk_wait(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            set_rx(idx, pl[i]);
            clk_wait(BIT_CLK);
        end
        if (idx == 1) begin
            set_rx(idx, pbit);
            clk_wait(BIT_CLK);
        end
        set_rx(idx, stop);
        clk_wait(BIT_CLK);
    endtask

    task automatic random_frames(input int idx, input int n);
        logic [7:0] pl;
        logic       pbit;
        logic       stop;
        for (int k = 0; k < n; k++) begin
            pl   = 8'($urandom_range(0, 255));
            pbit = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 4) != 0);
            send_frame(idx, pl, pbit, stop);
            if (!stop) begin
                clk_wait($urandom_range(200, 400));
                set_rx(idx, 1'b1);
                clk_wait(4);
            end
            clk_wait($urandom_range(0, 200));
        end
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        last_data[0] = 8'h00;
        last_data[1] = 8'h00;
        bus0.rx = 1'b1;
        bus1.rx = 1'b1;
        rst = 1'b1;
        clk_wait(5);
        chk("reset_outputs_dut0", 32'({bus0.data, bus0.valid, bus0.frame_err, bus0.parity_err, bus0.busy}), 32'h0);
        chk("reset_outputs_dut1", 32'({bus1.data, bus1.valid, bus1.frame_err, bus1.parity_err, bus1.busy}), 32'h0);
        rst = 1'b0;
        clk_wait(5);

        send_frame(0, 8'hA5, 1'b0, 1'b1);
        clk_wait(20);
        chk("busy_after_a5", 32'(bus0.busy), 32'h0);

        set_rx(0, 1'b0);
        clk_wait(40);
        set_rx(0, 1'b1);
        clk_wait(30);
        chk("busy_during_glitch", 32'(bus0.busy), 32'h1);
        clk_wait(30);
        chk("busy_after_glitch", 32'(bus0.busy), 32'h0);
        clk_wait(100);

        send_frame(0, 8'h3C, 1'b0, 1'b0);
        clk_wait(500);
        chk("busy_during_break", 32'(bus0.busy), 32'h1);
        chk("data_held_in_break", 32'(bus0.data), 32'hA5);
        clk_wait(500);
        set_rx(0, 1'b1);
        clk_wait(4);
        chk("busy_after_break", 32'(bus0.busy), 32'h0);
        send_frame(0, 8'h81, 1'b0, 1'b1);

        send_frame(0, 8'h00, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b1);
        clk_wait(20);

        set_rx(0, 1'b0);
        clk_wait(BIT_CLK);
        for (int i = 0; i < 3; i++) begin
            set_rx(0, 1'(i % 2));
            clk_wait(BIT_CLK);
        end
        clk_wait(BIT_CLK / 2);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_dut0", 32'({bus0.data, bus0.valid, bus0.frame_err, bus0.parity_err, bus0.busy}), 32'h0);
        set_rx(0, 1'b1);
        last_data[0] = 8'h00;
        last_data[1] = 8'h00;
        clk_wait(3);
        rst = 1'b0;
        clk_wait(5);
        send_frame(0, 8'h55, 1'b0, 1'b1);

        send_frame(1, 8'h07, 1'b0, 1'b1);
        send_frame(1, 8'h07, 1'b1, 1'b1);
        clk_wait(20);

        random_frames(0, 6);
        random_frames(1, 6);

        clk_wait(400);
        chk("sb0_drained", 32'(sb0.size()), 32'h0);
        chk("sb1_drained", 32'(sb1.size()), 32'h0);
        chk("final_busy", 32'({bus0.busy, bus1.busy}), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
